// File: rtl/eqed_ctrl_pkg.sv
// Shared types and constants for the EQED bit-flip injection campaign controller.
package eqed_ctrl_pkg;

  localparam int DEF_NUM_FF     = 8;
  localparam int DEF_CNT_W      = 10;
  localparam int DEF_SIG_W      = 6;
  localparam int DUT_RST_CYCLES = 2;

  typedef enum logic [2:0] {
    IDLE,
    DUT_RST,
    WAIT_INJ,
    INJECT,
    OBSERVE,
    COMPARE,
    NEXT,
    FIN
  } state_t;

endpackage

// File: rtl/eqed_onehot_dec.sv
// Binary index to one-hot select decoder; output is all-zero unless enabled.
module eqed_onehot_dec #(
  parameter int N  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic [IW-1:0] idx,
  input  logic          en,
  output logic [N-1:0]  onehot
);

  // NOTE: combinational blocks assign every output a default first so no latch is inferred.
  always_comb begin
    onehot = '0;
    if (en) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/eqed_inject_ctrl.sv
// EQED injection campaign controller: one single-bit-flip run per flip-flop, MISR compare per run.
// Optional build macro EQED_GOLDEN_CAPTURE_EN adds a fault-free golden-capture run per campaign.
module eqed_inject_ctrl
  import eqed_ctrl_pkg::*;
#(
  parameter int NUM_FF = DEF_NUM_FF,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int SIG_W  = DEF_SIG_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       abort,
  input  logic [CNT_W-1:0]           inj_cycle,
  input  logic [CNT_W-1:0]           obs_len,
  input  logic [SIG_W-1:0]           sig_in,
  input  logic [SIG_W-1:0]           golden_sig,
  output logic                       dut_rst,
  output logic [NUM_FF-1:0]          sel_out,
  output logic                       busy,
  output logic                       result_valid,
  output logic [$clog2(NUM_FF)-1:0]  result_ff_idx,
  output logic                       result_detected,
  output logic [$clog2(NUM_FF+1)-1:0] detect_cnt,
  output logic                       done
);

  localparam int IDX_W  = $clog2(NUM_FF);
  localparam int DCNT_W = $clog2(NUM_FF + 1);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [CNT_W-1:0]   inj_q, obs_q, eff_inj, eff_obs;
  logic [IDX_W-1:0]   ff_idx;
  logic [DCNT_W-1:0]  det_q;
  logic [IDX_W-1:0]   res_idx_q;
  logic               res_det_q;
  logic [SIG_W-1:0]   ref_sig;
  logic               golden_run;
  logic               mismatch;
  logic               last_ff;
  logic               inj_en;
  logic               abort_now;

  // Zero timing values behave as one cycle.
  assign eff_inj   = (inj_q == '0) ? ONE : inj_q;
  assign eff_obs   = (obs_q == '0) ? ONE : obs_q;
  assign last_ff   = (ff_idx == IDX_W'(NUM_FF - 1));
  assign mismatch  = (sig_in != ref_sig);
  assign abort_now = abort && (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // cnt is the per-phase cycle counter; WAIT_INJ starts at 1 on the first cycle after dut_rst falls,
  // so INJECT lands exactly on cycle eff_inj.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    if (abort_now) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state_next = DUT_RST;
            cnt_next   = '0;
          end
        end
        DUT_RST: begin
          if (cnt == CNT_W'(DUT_RST_CYCLES - 1)) begin
            cnt_next   = ONE;
            state_next = (eff_inj == ONE) ? INJECT : WAIT_INJ;
          end else begin
            cnt_next = cnt + ONE;
          end
        end
        WAIT_INJ: begin
          if (cnt == eff_inj - ONE) state_next = INJECT;
          else                      cnt_next   = cnt + ONE;
        end
        INJECT: begin
          state_next = OBSERVE;
          cnt_next   = ONE;
        end
        OBSERVE: begin
          if (cnt == eff_obs) state_next = COMPARE;
          else                cnt_next   = cnt + ONE;
        end
        COMPARE: begin
          // The golden run restarts the DUT for flip-flop 0 instead of advancing.
          state_next = golden_run ? DUT_RST : NEXT;
          cnt_next   = '0;
        end
        NEXT: begin
          state_next = last_ff ? FIN : DUT_RST;
          cnt_next   = '0;
        end
        FIN:     state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  assign dut_rst      = (state == DUT_RST);
  assign busy         = (state != IDLE);
  assign inj_en       = (state == INJECT) && !abort_now && !golden_run;
  assign result_valid = (state == COMPARE) && !abort_now && !golden_run;
  assign done         = (state == FIN) && !abort_now;

  // Live values during the compare pulse, held values afterwards.
  assign result_ff_idx   = result_valid ? ff_idx   : res_idx_q;
  assign result_detected = result_valid ? mismatch : res_det_q;
  assign detect_cnt      = det_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      inj_q     <= '0;
      obs_q     <= '0;
      ff_idx    <= '0;
      det_q     <= '0;
      res_idx_q <= '0;
      res_det_q <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        inj_q  <= inj_cycle;
        obs_q  <= obs_len;
        ff_idx <= '0;
        det_q  <= '0;
      end
      if (result_valid) begin
        res_idx_q <= ff_idx;
        res_det_q <= mismatch;
        if (mismatch && det_q != DCNT_W'(NUM_FF)) det_q <= det_q + DCNT_W'(1);
      end
      if (state == NEXT && !abort_now && !last_ff) ff_idx <= ff_idx + IDX_W'(1);
    end
  end

`ifdef EQED_GOLDEN_CAPTURE_EN
  logic [SIG_W-1:0] golden_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      golden_run <= 1'b0;
      golden_q   <= '0;
    end else if (state == IDLE && start) begin
      golden_run <= 1'b1;
    end else if (abort_now) begin
      golden_run <= 1'b0;
    end else if (state == COMPARE && golden_run) begin
      golden_q   <= sig_in;
      golden_run <= 1'b0;
    end
  end

  assign ref_sig = golden_q;
`else
  assign golden_run = 1'b0;
  assign ref_sig    = golden_sig;
`endif

  eqed_onehot_dec #(
    .N  (NUM_FF),
    .IW (IDX_W)
  ) u_sel_dec (
    .idx    (ff_idx),
    .en     (inj_en),
    .onehot (sel_out)
  );

endmodule

// File: tb/tb_eqed_inject_ctrl.sv
// Directed self-checking bench for eqed_inject_ctrl (golden-capture scenario when EQED_GOLDEN_CAPTURE_EN is defined).
module tb_eqed_inject_ctrl;

  localparam int NUM_FF = 8;
  localparam int CNT_W  = 10;
  localparam int SIG_W  = 6;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [CNT_W-1:0]  inj_cycle = '0;
  logic [CNT_W-1:0]  obs_len = '0;
  logic [SIG_W-1:0]  sig_in = '0;
  logic [SIG_W-1:0]  golden_sig = '0;
  logic              dut_rst;
  logic [NUM_FF-1:0] sel_out;
  logic              busy;
  logic              result_valid;
  logic [2:0]        result_ff_idx;
  logic              result_detected;
  logic [3:0]        detect_cnt;
  logic              done;

  int checks = 0;
  int errors = 0;

  eqed_inject_ctrl #(.NUM_FF(NUM_FF), .CNT_W(CNT_W), .SIG_W(SIG_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .abort           (abort),
    .inj_cycle       (inj_cycle),
    .obs_len         (obs_len),
    .sig_in          (sig_in),
    .golden_sig      (golden_sig),
    .dut_rst         (dut_rst),
    .sel_out         (sel_out),
    .busy            (busy),
    .result_valid    (result_valid),
    .result_ff_idx   (result_ff_idx),
    .result_detected (result_detected),
    .detect_cnt      (detect_cnt),
    .done            (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One campaign; abort_run/rst_run/mid_start_run select the run that gets the disturbance (-1 = none).
  task automatic run_campaign(input logic [CNT_W-1:0] inj, input logic [CNT_W-1:0] obs,
                              input logic [7:0] mask, input int abort_run, input int rst_run,
                              input int mid_start_run);
    int ei, eo, det;
    logic [SIG_W-1:0] clean, dirty;
    ei  = (inj == 0) ? 1 : int'(inj);
    eo  = (obs == 0) ? 1 : int'(obs);
    det = 0;
`ifdef EQED_GOLDEN_CAPTURE_EN
    clean      = 6'h32;
    dirty      = 6'h12;
    golden_sig = dirty;
`else
    clean      = 6'h15;
    dirty      = 6'h14;
    golden_sig = clean;
`endif
    inj_cycle = inj;
    obs_len   = obs;
    sig_in    = clean;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    inj_cycle = 10'd7;
    obs_len   = 10'd9;
`ifdef EQED_GOLDEN_CAPTURE_EN
    check("gold_rst0", dut_rst, 1'b1);
    tick();
    check("gold_rst1", dut_rst, 1'b1);
    tick();
    for (int c = 1; c < ei; c++) tick();
    check("gold_no_inject", sel_out, '0);
    tick();
    for (int c = 0; c < eo; c++) begin
      check("gold_obs_sel", sel_out, '0);
      tick();
    end
    check("gold_no_result", result_valid, 1'b0);
    tick();
`endif
    for (int r = 0; r < NUM_FF; r++) begin
      sig_in = mask[r] ? dirty : clean;
      check("dut_rst_c0", dut_rst, 1'b1);
      check("busy_run", busy, 1'b1);
      tick();
      check("dut_rst_c1", dut_rst, 1'b1);
      tick();
      for (int c = 1; c < ei; c++) begin
        check("wait_dut_rst", dut_rst, 1'b0);
        check("wait_sel", sel_out, '0);
        tick();
      end
      check("inject_sel", sel_out, 32'(1) << r);
      check("inject_dut_rst", dut_rst, 1'b0);
      if (r == rst_run) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_sel", sel_out, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_detect_cnt", detect_cnt, '0);
        check("rst_dut_rst", dut_rst, 1'b0);
        check("rst_result_idx", result_ff_idx, '0);
        return;
      end
      tick();
      for (int c = 0; c < eo; c++) begin
        check("obs_sel", sel_out, '0);
        check("obs_no_result", result_valid, 1'b0);
        if (r == abort_run && c == eo / 2) begin
          abort = 1'b1;
          #1;
          check("abort_sel", sel_out, '0);
          check("abort_no_result", result_valid, 1'b0);
          tick();
          abort = 1'b0;
          for (int k = 0; k < 3; k++) begin
            check("abort_idle_busy", busy, 1'b0);
            check("abort_no_result_after", result_valid, 1'b0);
            check("abort_no_done", done, 1'b0);
            tick();
          end
          return;
        end
        if (r == mid_start_run && c == 0) start = 1'b1;
        tick();
        start = 1'b0;
      end
      check("cmp_valid", result_valid, 1'b1);
      check("cmp_idx", result_ff_idx, r);
      check("cmp_detected", result_detected, mask[r]);
      if (mask[r]) det++;
      tick();
      check("next_valid_low", result_valid, 1'b0);
      check("next_detect_cnt", detect_cnt, det);
      check("next_no_done", done, 1'b0);
      tick();
    end
    check("fin_done", done, 1'b1);
    check("fin_busy", busy, 1'b1);
    tick();
    check("after_done_low", done, 1'b0);
    check("after_busy", busy, 1'b0);
    check("final_detect_cnt", detect_cnt, det);
    check("hold_result_idx", result_ff_idx, 3'd7);
    check("hold_result_det", result_detected, mask[7]);
    tick();
    check("still_idle", busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    tick();
    rst = 1'b0;
    check("reset_busy", busy, 1'b0);
    check("reset_sel", sel_out, '0);
    check("reset_dut_rst", dut_rst, 1'b0);
    check("reset_valid", result_valid, 1'b0);
    check("reset_detected", result_detected, 1'b0);
    check("reset_idx", result_ff_idx, '0);
    check("reset_detect_cnt", detect_cnt, '0);
    check("reset_done", done, 1'b0);

    // abort alone in IDLE keeps the block idle
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_in_idle", busy, 1'b0);

    run_campaign(10'd3, 10'd5, 8'h00, -1, -1, -1);
    run_campaign(10'd3, 10'd5, 8'b0010_0100, -1, -1, -1);
    run_campaign(10'd2, 10'd4, 8'h00, 3, -1, -1);
    run_campaign(10'd0, 10'd0, 8'h81, -1, -1, 1);
    run_campaign(10'd1, 10'd1, 8'h01, -1, 1, -1);

    // start and abort together in IDLE: start wins
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("start_beats_abort", dut_rst, 1'b1);
    check("start_beats_abort_busy", busy, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/eqed_inject_ctrl.md
EQED_INJECT_CTRL -- requirements
Module: eqed_inject_ctrl

Interface
REQ-001 The block SHALL take parameter NUM_FF, default 8, as the number of injectable flip-flops, i.e. the width of the one-hot select bus.
REQ-002 The block SHALL take parameter CNT_W, default 10, as the width of the cycle counters and timing inputs.
REQ-003 The block SHALL take parameter SIG_W, default 6, as the MISR signature width.
REQ-004 The ports SHALL be as listed below; reset is rst, synchronous, active-high; clock is clk.
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  begin campaign; sampled in IDLE only.
- abort  in  1  terminate campaign.
- inj_cycle  in  CNT_W  cycles after DUT reset release before injection.
- obs_len  in  CNT_W  observation window length after injection.
- sig_in  in  SIG_W  output-MISR signature from harness.
- golden_sig  in  SIG_W  fault-free reference signature.
- dut_rst  out  1  reset to DUT and MISRs.
- sel_out  out  NUM_FF  one-hot bit-flip select to FF muxes.
- busy  out  1  campaign in progress.
- result_valid  out  1  one-cycle pulse per completed run.
- result_ff_idx  out  $clog2(NUM_FF)  FF index of the reported run.
- result_detected  out  1  sig_in differed from the golden signature.
- detect_cnt  out  $clog2(NUM_FF+1)  detected-run count.
- done  out  1  one-cycle campaign-complete pulse.

Function
REQ-005 The FSM SHALL have states IDLE, DUT_RST, WAIT_INJ, INJECT, OBSERVE, COMPARE, NEXT and FIN.
REQ-006 On start in IDLE, the block SHALL latch inj_cycle and obs_len, clear ff_idx and detect_cnt, and enter DUT_RST.
- start outside IDLE SHALL be ignored.
REQ-007 DUT_RST SHALL drive dut_rst high for exactly 2 cycles, then enter WAIT_INJ.
REQ-008 WAIT_INJ SHALL count from 1 on the first cycle after dut_rst falls, and enter INJECT when the count equals inj_cycle.
- inj_cycle=0 SHALL be treated as 1.
REQ-009 INJECT SHALL last exactly one cycle, with sel_out = 1<<ff_idx.
- In every other state sel_out SHALL be all-zero.
- At most one sel_out bit SHALL ever be high.
REQ-010 OBSERVE SHALL last obs_len cycles; obs_len=0 SHALL be treated as 1.
REQ-011 COMPARE SHALL last one cycle and pulse result_valid with result_ff_idx=ff_idx and result_detected=(sig_in != golden).
- On detection, detect_cnt SHALL increment; it saturates at NUM_FF.
REQ-012 NEXT: if ff_idx==NUM_FF-1, the FSM SHALL enter FIN; otherwise it SHALL increment ff_idx and enter DUT_RST.
REQ-013 FIN SHALL pulse done for one cycle and return to IDLE.
- detect_cnt and the last result_* values SHALL hold until the next start.
REQ-014 busy SHALL be high in every state except IDLE.
REQ-015 abort in any non-IDLE state SHALL force IDLE on the next edge.
- sel_out SHALL be zero that cycle, and no result_valid or done SHALL be issued.
- abort has priority over all other transitions.
REQ-016 abort and start together in IDLE: start SHALL win.

Reset
REQ-017 rst SHALL force IDLE with sel_out=0, dut_rst=0, busy=0, result_valid=0, result_detected=0, result_ff_idx=0, detect_cnt=0, done=0 and all counters 0, including when asserted mid-campaign.

Configuration
REQ-018 With EQED_GOLDEN_CAPTURE_EN defined, each campaign SHALL first execute one extra run with no injection (DUT_RST, WAIT_INJ, OBSERVE, with sel_out held zero).
- At the end of that run, sig_in SHALL be captured into an internal golden register, with no result_valid issued.
- All later compares SHALL use the captured value; the golden_sig port SHALL remain present but be ignored.
REQ-019 Without EQED_GOLDEN_CAPTURE_EN, there SHALL be no golden run, and golden_sig SHALL be used directly.

Structure
REQ-020 Package eqed_ctrl_pkg SHALL hold the state enum, the DUT_RST_CYCLES=2 constant, and the default NUM_FF/CNT_W/SIG_W values.
REQ-021 The binary-to-one-hot select SHALL be sub-module eqed_onehot_dec (inputs idx, en; output onehot), instantiated once.

Verification
REQ-022 The bench SHALL cover the following directed scenarios:
- NUM_FF=8, inj_cycle=3, obs_len=5, start -> sel_out=8'h01 exactly on the 3rd cycle after dut_rst falls; 8 result_valid pulses with idx 0..7 in order; then a single done pulse.
- sig_in==golden_sig on all runs -> detect_cnt=0; sig_in differs only on runs 2 and 5 -> result_detected high only on those runs, and detect_cnt=2.
- abort during OBSERVE of run 3 -> IDLE next cycle, sel_out=0, no result for run 3, no done.
- inj_cycle=0, obs_len=0 -> injection on cycle 1, compare one cycle later; start pulsed while busy -> no effect.
- rst asserted during INJECT -> next cycle sel_out=0, busy=0, detect_cnt=0.
- EQED_GOLDEN_CAPTURE_EN, clean run sig_in=6'h32, later runs 6'h32/6'h12 -> the first result_valid refers to idx 0; 6'h12 runs are flagged detected; golden_sig is ignored.
